// File: rtl/tree_reduce_ctrl_pkg.sv
// Shared definitions for the tree reduction controller: FSM state encoding,
// width helpers and default parameter values.
package tree_reduce_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_W       = 4;
    localparam int DEFAULT_M       = 8;
    localparam int DEFAULT_ADD_LAT = 1;

    // Width of a full reduction result: M operands of w bits never exceed w + clog2(m) bits.
    function automatic int sum_width(input int w, input int m);
        return w + $clog2(m);
    endfunction

    // Bits needed to hold every value in 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tree_operand_bank.sv
// M x SW operand register bank with one write port and two combinational read ports.
module tree_operand_bank
    import tree_reduce_ctrl_pkg::*;
#(
    parameter int M = DEFAULT_M,
    parameter int SW = sum_width(DEFAULT_W, DEFAULT_M),
    localparam int AW = cnt_width(M - 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [SW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [SW-1:0] rdata_a,
    output logic [SW-1:0] rdata_b
);

    logic [SW-1:0] mem [M];

    // Storage update: reset clears every entry so a discarded job leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < M; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/tree_reduce_ctrl.sv
// Sequential binary-tree reduction controller: loads M operands, walks the
// tree one pair at a time through an external adder stage, and presents the sum.
module tree_reduce_ctrl
    import tree_reduce_ctrl_pkg::*;
#(
    parameter int W = DEFAULT_W,
    parameter int M = DEFAULT_M,
    parameter int ADD_LAT = DEFAULT_ADD_LAT,
    localparam int SW = sum_width(W, M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic [SW-1:0] add_a,
    output logic [SW-1:0] add_b,
    output logic          add_cin,
    output logic          add_go,
    input  logic [SW-1:0] add_s,
    input  logic          add_cout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic          out_err
);

    localparam int AW = cnt_width(M - 1);
    localparam int NW = cnt_width(M);
    localparam int TW = cnt_width(ADD_LAT);
    localparam logic [AW-1:0] K_LAST = AW'(M - 1);
    localparam logic [TW-1:0] T_LAST = TW'(ADD_LAT);
    localparam logic [NW-1:0] N_FULL = NW'(M);

    state_t        state;
    logic [AW-1:0] k;
    logic [AW-1:0] j;
    logic [NW-1:0] n;
    logic [TW-1:0] t;
    logic          err_flag;

    logic          bank_we;
    logic [AW-1:0] bank_waddr;
    logic [SW-1:0] bank_wdata;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [SW-1:0] rd_a;
    logic [SW-1:0] rd_b;

    logic          load_fire;
    logic          capture;
    logic [NW-1:0] half_n;
    logic          pair_more;
    logic          last_level;

    tree_operand_bank #(
        .M  (M),
        .SW (SW)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (bank_we),
        .waddr   (bank_waddr),
        .wdata   (bank_wdata),
        .raddr_a (rd_addr_a),
        .raddr_b (rd_addr_b),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    // Handshake strobes, tree-walk decisions and the bank write-port mux (load data vs. adder sum).
    always_comb begin
        load_fire  = (state == ST_LOAD) && in_valid && in_ready;
        capture    = (state == ST_ADD) && (t == T_LAST);
        half_n     = n >> 1;
        pair_more  = (NW'(j) + NW'(1)) < half_n;
        last_level = (half_n == NW'(1));
        bank_we    = load_fire || capture;
        bank_waddr = (state == ST_LOAD) ? k : j;
        bank_wdata = (state == ST_LOAD) ? SW'(in_data) : add_s;
        rd_addr_a  = AW'({j, 1'b0});
        rd_addr_b  = rd_addr_a | AW'(1);
    end

    // Operands come straight from the bank and are held by j staying fixed for the whole pair.
    assign add_a   = (state == ST_ADD) ? rd_a : '0;
    assign add_b   = (state == ST_ADD) ? rd_b : '0;
    assign add_cin = 1'b0;

    // Main FSM: load counter, tree walk with latency counter, result hand-off and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            k         <= '0;
            j         <= '0;
            n         <= N_FULL;
            t         <= '0;
            err_flag  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_err   <= 1'b0;
            add_go    <= 1'b0;
        end else begin
            add_go <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (load_fire) begin
                        if (k == K_LAST) begin
                            state    <= ST_ADD;
                            k        <= '0;
                            j        <= '0;
                            n        <= N_FULL;
                            t        <= '0;
                            in_ready <= 1'b0;
                            add_go   <= 1'b1;
                        end else begin
                            k <= k + AW'(1);
                        end
                    end
                end
                ST_ADD: begin
                    if (capture) begin
                        err_flag <= err_flag | add_cout;
                        t        <= '0;
                        if (pair_more) begin
                            j      <= j + AW'(1);
                            add_go <= 1'b1;
                        end else begin
                            n <= half_n;
                            j <= '0;
                            if (last_level) begin
                                state     <= ST_DONE;
                                out_valid <= 1'b1;
                                out_sum   <= add_s;
                                out_err   <= err_flag | add_cout;
                            end else begin
                                add_go <= 1'b1;
                            end
                        end
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_LOAD;
                        k         <= '0;
                        n         <= N_FULL;
                        err_flag  <= 1'b0;
                        out_valid <= 1'b0;
                        out_sum   <= '0;
                        out_err   <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_LOAD;
                    k        <= '0;
                    j        <= '0;
                    n        <= N_FULL;
                    t        <= '0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tree_reduce_ctrl.sv
// Directed bench for tree_reduce_ctrl: three lanes with adder latencies 1, 0 and 3,
// each paired with a delay-line stub adder that can inject a carry-out fault.
module tb_tree_reduce_ctrl;

    localparam int W  = 4;
    localparam int M  = 8;
    localparam int SW = 7;

    logic clk = 1'b0;
    logic rst;

    logic          in_valid   [3];
    logic [W-1:0]  in_data    [3];
    logic          out_ready  [3];
    logic          fault_en   [3];

    logic          in_ready_w  [3];
    logic [SW-1:0] add_a_w     [3];
    logic [SW-1:0] add_b_w     [3];
    logic          add_cin_w   [3];
    logic          add_go_w    [3];
    logic [SW-1:0] add_s_w     [3];
    logic          add_cout_w  [3];
    logic          out_valid_w [3];
    logic [SW-1:0] out_sum_w   [3];
    logic          out_err_w   [3];

    int   go_cnt_a   [3];
    int   min_run_a  [3];
    int   max_run_a  [3];
    logic unstable_a [3];

    logic [W-1:0] vec [8];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t_first  = 0;
    int lat;

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        localparam int DI  = (LAT == 0) ? 0 : LAT - 1;

        logic [SW-1:0] sum_now;
        logic [SW-1:0] dl [4];
        int            go_cnt   = 0;
        int            run_len  = 0;
        int            min_run  = 1000;
        int            max_run  = 0;
        logic          run_open = 1'b0;
        logic          unstable = 1'b0;
        logic [SW-1:0] la;
        logic [SW-1:0] lb;

        tree_reduce_ctrl #(.W(W), .M(M), .ADD_LAT(LAT)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready_w[g]),
            .in_data   (in_data[g]),
            .add_a     (add_a_w[g]),
            .add_b     (add_b_w[g]),
            .add_cin   (add_cin_w[g]),
            .add_go    (add_go_w[g]),
            .add_s     (add_s_w[g]),
            .add_cout  (add_cout_w[g]),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready[g]),
            .out_sum   (out_sum_w[g]),
            .out_err   (out_err_w[g])
        );

        assign sum_now = add_a_w[g] + add_b_w[g];

        // Stub adder pipeline: the sum appears LAT edges after the operands.
        always @(posedge clk) begin
            dl[0] <= sum_now;
            for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
        end

        assign add_s_w[g]    = (LAT == 0) ? sum_now : dl[DI];
        assign add_cout_w[g] = fault_en[g] && (go_cnt == 5);

        // Pair monitor: counts add_go pulses and measures how long each pair's operands stay put.
        always begin
            @(posedge clk);
            #2;
            if (in_ready_w[g] === 1'b1) begin
                go_cnt   = 0;
                run_open = 1'b0;
                min_run  = 1000;
                max_run  = 0;
                unstable = 1'b0;
            end else if (add_go_w[g] === 1'b1) begin
                if (run_open) begin
                    if (run_len < min_run) min_run = run_len;
                    if (run_len > max_run) max_run = run_len;
                end
                go_cnt   = go_cnt + 1;
                run_open = 1'b1;
                run_len  = 1;
                la       = add_a_w[g];
                lb       = add_b_w[g];
            end else if (run_open) begin
                if (out_valid_w[g] === 1'b1) begin
                    if (run_len < min_run) min_run = run_len;
                    if (run_len > max_run) max_run = run_len;
                    run_open = 1'b0;
                end else begin
                    run_len = run_len + 1;
                    if (add_a_w[g] !== la || add_b_w[g] !== lb) unstable = 1'b1;
                end
            end
        end

        assign go_cnt_a[g]   = go_cnt;
        assign min_run_a[g]  = min_run;
        assign max_run_a[g]  = max_run;
        assign unstable_a[g] = unstable;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic setVec(input int kind);
        logic [W-1:0] mixed [8];
        mixed = '{4'd3, 4'd0, 4'd15, 4'd7, 4'd9, 4'd2, 4'd11, 4'd5};
        for (int i = 0; i < 8; i++) begin
            if (kind == 1)      vec[i] = W'(i + 1);
            else if (kind == 2) vec[i] = 4'd15;
            else                vec[i] = mixed[i];
        end
    endtask

    // Starts and ends just after a rising edge; optional two-cycle idle gap after operand gap_after.
    task automatic applyStimulus(input int idx, input int count, input int gap_after);
        logic rdy;
        int   tries;
        for (int i = 0; i < count; i++) begin
            in_valid[idx] = 1'b1;
            in_data[idx]  = vec[i];
            tries = 0;
            do begin
                @(negedge clk);
                rdy = in_ready_w[idx];
                @(posedge clk);
                #1;
                tries++;
            end while (rdy !== 1'b1 && tries < 50);
            if (rdy !== 1'b1) check("load_timeout", {31'd0, rdy}, 1);
            if (i == 0) t_first = cyc;
            if (i == gap_after) begin
                in_valid[idx] = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
        end
        in_valid[idx] = 1'b0;
    endtask

    // Ends on a falling edge with out_valid seen (or the bound expired).
    task automatic waitDone(input int idx, input int limit, output int latency);
        int n = 0;
        @(negedge clk);
        while (out_valid_w[idx] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, out_valid_w[idx]}, 1);
        latency = cyc - t_first;
    endtask

    task automatic checkOutput(input int idx, input string tag, input int exp_sum, input int exp_err);
        check({tag, "_valid"}, {31'd0, out_valid_w[idx]}, 1);
        check({tag, "_sum"}, {25'd0, out_sum_w[idx]}, exp_sum);
        check({tag, "_err"}, {31'd0, out_err_w[idx]}, exp_err);
    endtask

    task automatic checkStats(input int idx, input string tag, input int exp_run);
        check({tag, "_go_count"}, go_cnt_a[idx], 7);
        check({tag, "_min_hold"}, min_run_a[idx], exp_run);
        check({tag, "_max_hold"}, max_run_a[idx], exp_run);
        check({tag, "_unstable"}, {31'd0, unstable_a[idx]}, 0);
    endtask

    task automatic checkReset(input int idx, input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready_w[idx]}, 1);
        check({tag, "_out_valid"}, {31'd0, out_valid_w[idx]}, 0);
        check({tag, "_out_sum"}, {25'd0, out_sum_w[idx]}, 0);
        check({tag, "_out_err"}, {31'd0, out_err_w[idx]}, 0);
        check({tag, "_add_a"}, {25'd0, add_a_w[idx]}, 0);
        check({tag, "_add_b"}, {25'd0, add_b_w[idx]}, 0);
        check({tag, "_add_go"}, {31'd0, add_go_w[idx]}, 0);
        check({tag, "_add_cin"}, {31'd0, add_cin_w[idx]}, 0);
    endtask

    // Called on a falling edge in DONE; ends just after a rising edge.
    task automatic finishJob(input int idx, input string tag);
        in_valid[idx]  = 1'b0;
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
        @(negedge clk);
        check({tag, "_next_in_ready"}, {31'd0, in_ready_w[idx]}, 1);
        check({tag, "_next_out_valid"}, {31'd0, out_valid_w[idx]}, 0);
        @(posedge clk);
        #1;
    endtask

    // Safety net against a hung design.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            out_ready[i] = 1'b0;
            fault_en[i]  = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkReset(0, "reset");
        @(posedge clk);
        #1;

        $display("[TB] job 1..8, latency 1");
        setVec(1);
        applyStimulus(0, 8, -1);
        waitDone(0, 100, lat);
        check("jobA_latency", lat, 21);
        checkOutput(0, "jobA", 36, 0);
        checkStats(0, "jobA", 2);

        $display("[TB] hold DONE with in_valid high");
        in_valid[0] = 1'b1;
        in_data[0]  = 4'd9;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_sum", {25'd0, out_sum_w[0]}, 36);
            check("hold_in_ready", {31'd0, in_ready_w[0]}, 0);
            check("hold_valid", {31'd0, out_valid_w[0]}, 1);
        end
        finishJob(0, "jobA");

        $display("[TB] job all 15 with a load stall");
        setVec(2);
        applyStimulus(0, 8, 3);
        waitDone(0, 100, lat);
        checkOutput(0, "jobB", 120, 0);
        checkStats(0, "jobB", 2);
        finishJob(0, "jobB");

        $display("[TB] carry-out fault on pair 5");
        fault_en[0] = 1'b1;
        setVec(1);
        applyStimulus(0, 8, -1);
        waitDone(0, 100, lat);
        checkOutput(0, "fault", 36, 1);
        finishJob(0, "fault");
        fault_en[0] = 1'b0;

        setVec(3);
        applyStimulus(0, 8, -1);
        waitDone(0, 100, lat);
        checkOutput(0, "clean", 52, 0);
        finishJob(0, "clean");

        $display("[TB] reset mid-load and mid-pair");
        setVec(1);
        applyStimulus(0, 5, -1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkReset(0, "rst_load");
        @(posedge clk);
        #1;

        applyStimulus(0, 8, -1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midpair_go", {31'd0, add_go_w[0]}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkReset(0, "rst_pair");
        @(posedge clk);
        #1;

        applyStimulus(0, 8, -1);
        waitDone(0, 100, lat);
        check("fresh_latency", lat, 21);
        checkOutput(0, "fresh", 36, 0);
        finishJob(0, "fresh");

        $display("[TB] latency 0 lane");
        setVec(1);
        applyStimulus(1, 8, -1);
        waitDone(1, 100, lat);
        check("lat0_latency", lat, 14);
        checkOutput(1, "lat0", 36, 0);
        checkStats(1, "lat0", 1);
        finishJob(1, "lat0");

        $display("[TB] latency 3 lane");
        setVec(3);
        applyStimulus(2, 8, -1);
        waitDone(2, 100, lat);
        check("lat3_latency", lat, 35);
        checkOutput(2, "lat3", 52, 0);
        checkStats(2, "lat3", 4);
        finishJob(2, "lat3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tree_reduce_ctrl.md
# tree_reduce_ctrl

Sequential multi-operand reduction controller for the binary-tree adder datapath. It collects M operands over a valid/ready stream into an in-place register bank. It then walks the tree level by level, issuing one operand pair at a time to an external SW-bit ripple-carry adder stage and writing each sum back into the bank. It presents the final sum on a valid/ready output. It sits directly upstream of the adder stage, drives its `a`/`b`/`cin` inputs, and consumes its `s`/`cout` outputs.

## Interface
- `W`, 4: operand width.
- `M`, 8: operands per job; power of two, ≥ 2.
- `ADD_LAT`, 1: adder stage latency in clock edges from operand presentation to valid `s`/`cout`; ≥ 0.
- `SW` (derived, not overridable): W + clog2(M), the sum and adder width.

Ports:
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand available.
- `in_ready` output 1: block accepts an operand.
- `in_data` input W: operand.
- `add_a` output SW: adder operand A.
- `add_b` output SW: adder operand B.
- `add_cin` output 1: adder carry-in; constant 0.
- `add_go` output 1: one-cycle pulse on the first cycle a pair is presented.
- `add_s` input SW: adder sum.
- `add_cout` input 1: adder carry-out.
- `out_valid` output 1: final sum available.
- `out_ready` input 1: consumer accepts the sum.
- `out_sum` output SW: reduction result.
- `out_err` output 1: a carry-out was captured during the current job.

## Operation
- States: LOAD, ADD, DONE.
- LOAD
  - `in_ready`=1.
  - Each `in_valid & in_ready` cycle writes `in_data`, zero-extended to SW, into `bank[k]` and increments k.
  - When k reaches M-1 and that operand is accepted, go to ADD with level size n=M and pair index j=0.
- ADD
  - Drive `add_a`=`bank[2j]` and `add_b`=`bank[2j+1]`; hold both stable for the whole pair.
  - A latency counter t starts at 0 and increments each cycle.
  - When t==ADD_LAT: write `bank[j]` ← `add_s`, OR `add_cout` into the error flag, clear t, then advance.
  - Advance: j+1 if j+1 < n/2. Otherwise n ← n/2 and j ← 0; if the new n==1, go to DONE.
  - In-place writeback is safe because j ≤ 2j for every pair.
- DONE
  - `out_valid`=1, `out_sum`=`bank[0]`, `out_err`=flag.
  - On `out_ready`, go to LOAD, reset k, and clear the flag.
  - `out_sum` and `out_err` stay stable while `out_valid` is high and `out_ready` is low.
- Arithmetic: the sum of M W-bit values fits in SW bits, so `add_cout`=1 means an adder fault. It is recorded in `out_err` only; the result is not corrected.
- Outside ADD: `add_a`=`add_b`=0 and `add_go`=0.

## Timing
- Reset values:
  - state=LOAD, k=0, t=0, j=0, n=M.
  - Bank cleared, error flag cleared.
  - `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_err`=0, `add_a`=`add_b`=0, `add_go`=0, `add_cin`=0.
- Load takes ≥ M cycles; idle `in_valid` cycles stall it with no other effect.
- Each pair occupies ADD_LAT+1 cycles. A reduction takes (M-1)(ADD_LAT+1) cycles.
- `out_valid` rises on the cycle after the final capture.
- `add_go` is high exactly on cycle t==0 of each pair.
- `in_valid` during ADD/DONE is ignored (`in_ready`=0); no operand is lost or overwritten.
- `out_ready` outside DONE is ignored.
- An `out_ready` handshake in DONE makes `in_ready`=1 on the next cycle. There is no zero-bubble bypass from out to in.
- `rst` in any state, including mid-load, mid-pair and while DONE is waiting, returns to reset values on the next edge. Partial jobs are discarded.
- `rst` has priority over every handshake in the same cycle.

## Structure
- Shared package:
  - state encoding (LOAD/ADD/DONE);
  - SW derivation function;
  - default parameter constants.
- One natural sub-module: `tree_operand_bank`, an M×SW register array with one write port and two combinational read ports.
  - The write-port mux (load data vs. `add_s`) stays in the controller.
- Controller holds the FSM, the k/j/n/t counters and the error flag.

## Test plan
- W=4, M=8, ADD_LAT=1; operands 1..8, a stub adder registering `a+b` → `out_sum`=36 and `out_err`=0. `out_valid` rises 8 load cycles plus 14 ADD cycles after the first accept.
- All operands 15, W=4, M=8 → `out_sum`=120 (fits SW=7). `add_go` pulses exactly 7 times.
- ADD_LAT=0 with a combinational stub, then ADD_LAT=3 → same sums. Each pair's `add_a`/`add_b` stays stable for exactly ADD_LAT+1 cycles.
- Stub forces `add_cout`=1 on the 5th pair → `out_err`=1 with `out_sum` as computed. The next job with a clean adder → `out_err`=0.
- Hold `out_ready`=0 for 10 cycles in DONE while `in_valid`=1 → `out_sum` stable and `in_ready`=0. Release → next job loads correctly.
- Assert `rst` after 5 operands, and again mid-pair → all outputs at reset values the next cycle. A fresh 8-operand job then gives the correct sum.
